// File: rtl/dlsc_stereobm_window_adder_pkg.sv
// Shared sizing helpers for the stereo block-matching window adder.
// Latency and internal width are derived here so every file agrees on them.
package dlsc_stereobm_adder_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int lat0_f(input int sad);
      return clog2(sad);
   endfunction

   function automatic int lat_f(input int sad, input int mult_r);
      return clog2(sad) + mult_r;
   endfunction

   // One spare bit on top of the window sum keeps prev + add headroom before the subtract.
   function automatic int int_bits_f(input int data, input int sad);
      return data + clog2(sad) + 1;
   endfunction

   localparam int DEF_DATA     = 16;
   localparam int DEF_SAD      = 15;
   localparam int DEF_MULT_R   = 3;
   localparam int DEF_LAT0     = lat0_f(DEF_SAD);
   localparam int DEF_LAT      = lat_f(DEF_SAD, DEF_MULT_R);
   localparam int DEF_INT_BITS = int_bits_f(DEF_DATA, DEF_SAD);

   typedef logic [DEF_INT_BITS-1:0] sum_t;

endpackage

// File: rtl/dlsc_stereobm_window_adder_slice.sv
// One incremental window stage: delays the entering/leaving terms into alignment
// with the previous window, then registers prev + add - sub.
module dlsc_stereobm_window_adder_slice
   import dlsc_stereobm_adder_pkg::*;
#(
   parameter int DATA     = 16,
   parameter int INT_BITS = 21,
   parameter int DLY      = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_en,
   input  logic [INT_BITS-1:0] i_prev,
   input  logic [DATA-1:0]     i_add,
   input  logic [DATA-1:0]     i_sub,
   output logic [INT_BITS-1:0] o_sum
);

   logic [DATA-1:0]     w_add;
   logic [DATA-1:0]     w_sub;
   logic [INT_BITS-1:0] r_sum;

   generate
      if (DLY == 0) begin : g_nodly
         assign w_add = i_add;
         assign w_sub = i_sub;
      end else begin : g_dly
         logic [DATA-1:0] r_add [DLY];
         logic [DATA-1:0] r_sub [DLY];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int d = 0; d < DLY; d++) begin
                  r_add[d] <= '0;
                  r_sub[d] <= '0;
               end
            end else if (i_en) begin
               r_add[0] <= i_add;
               r_sub[0] <= i_sub;
               for (int d = 1; d < DLY; d++) begin
                  r_add[d] <= r_add[d-1];
                  r_sub[d] <= r_sub[d-1];
               end
            end
         end
         assign w_add = r_add[DLY-1];
         assign w_sub = r_sub[DLY-1];
      end
   endgenerate

   // The leaving term is always part of i_prev, so the result never goes negative.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= '0;
      end else if (i_en) begin
         r_sum <= i_prev + INT_BITS'(w_add) - INT_BITS'(w_sub);
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/dlsc_stereobm_window_adder.sv
// Stall-able sliding-window SAD adder: MULT_R overlapping window sums with valid/ready.
// Define DLSC_STEREOBM_ADDER_SAT_EN to clamp output sums instead of wrapping them.
module dlsc_stereobm_window_adder
   import dlsc_stereobm_adder_pkg::*;
#(
   parameter int DATA     = 16,
   parameter int SAD      = 15,
   parameter int MULT_R   = 3,
   parameter int SUM_BITS = DATA + 4,
   parameter int META     = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [META-1:0]                   in_meta,
   input  logic [DATA*(SAD+MULT_R-1)-1:0]    in_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [META-1:0]                   out_meta,
   output logic [SUM_BITS*MULT_R-1:0]        out_data
);

   localparam int LAT0     = lat0_f(SAD);
   localparam int LAT      = lat_f(SAD, MULT_R);
   localparam int INT_BITS = int_bits_f(DATA, SAD);
   localparam int NLEAF    = 1 << LAT0;

   typedef logic [INT_BITS-1:0] isum_t;

   logic                       w_adv;
   isum_t                      w_win     [MULT_R];
   isum_t                      w_aligned [MULT_R];
   logic [SUM_BITS*MULT_R-1:0] w_conv;
   logic [LAT-1:0]             r_vld;
   logic [META-1:0]            r_meta    [LAT];
   logic [SUM_BITS*MULT_R-1:0] r_out_data;

   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   generate
      if (LAT0 == 0) begin : g_notree
         assign w_win[0] = INT_BITS'(in_data[0 +: DATA]);
      end else begin : g_tree
         // Heap-ordered tree: node i sums nodes 2i and 2i+1; leaves pad to a power of two with zeros.
         isum_t w_node [2:2*NLEAF-1];
         isum_t r_node [1:NLEAF-1];
         always_comb begin
            for (int i = 2; i < 2*NLEAF; i++) begin
               if (i < NLEAF) begin
                  w_node[i] = r_node[i];
               end else if ((i - NLEAF) < SAD) begin
                  w_node[i] = INT_BITS'(in_data[(i-NLEAF)*DATA +: DATA]);
               end else begin
                  w_node[i] = '0;
               end
            end
         end
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 1; i < NLEAF; i++) r_node[i] <= '0;
            end else if (w_adv) begin
               for (int i = 1; i < NLEAF; i++) r_node[i] <= w_node[2*i] + w_node[2*i+1];
            end
         end
         assign w_win[0] = r_node[1];
      end

      for (genvar j = 1; j < MULT_R; j++) begin : g_slice
         dlsc_stereobm_window_adder_slice #(
            .DATA     (DATA),
            .INT_BITS (INT_BITS),
            .DLY      (LAT0 + j - 1)
         ) u_slice (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_en   (w_adv),
            .i_prev (w_win[j-1]),
            .i_add  (in_data[(j+SAD-1)*DATA +: DATA]),
            .i_sub  (in_data[(j-1)*DATA +: DATA]),
            .o_sum  (w_win[j])
         );
      end

      // Early windows wait here so every window reaches the output register on the same beat.
      for (genvar j = 0; j < MULT_R; j++) begin : g_align
         localparam int D = MULT_R - 1 - j;
         if (D == 0) begin : g_pass
            assign w_aligned[j] = w_win[j];
         end else begin : g_dly
            isum_t r_dly [D];
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  for (int d = 0; d < D; d++) r_dly[d] <= '0;
               end else if (w_adv) begin
                  r_dly[0] <= w_win[j];
                  for (int d = 1; d < D; d++) r_dly[d] <= r_dly[d-1];
               end
            end
            assign w_aligned[j] = r_dly[D-1];
         end
      end

      for (genvar j = 0; j < MULT_R; j++) begin : g_conv
         if (SUM_BITS >= INT_BITS) begin : g_ext
            assign w_conv[j*SUM_BITS +: SUM_BITS] = SUM_BITS'(w_aligned[j]);
         end else begin : g_narrow
`ifdef DLSC_STEREOBM_ADDER_SAT_EN
            assign w_conv[j*SUM_BITS +: SUM_BITS] =
               (w_aligned[j] > isum_t'({SUM_BITS{1'b1}})) ? {SUM_BITS{1'b1}}
                                                         : w_aligned[j][SUM_BITS-1:0];
`else
            logic w_unused_hi;
            assign w_unused_hi = ^w_aligned[j][INT_BITS-1:SUM_BITS];
            assign w_conv[j*SUM_BITS +: SUM_BITS] = w_aligned[j][SUM_BITS-1:0];
`endif
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld      <= '0;
         r_out_data <= '0;
         for (int i = 0; i < LAT; i++) r_meta[i] <= '0;
      end else if (w_adv) begin
         r_vld[0]   <= in_valid;
         r_meta[0]  <= in_meta;
         r_out_data <= w_conv;
         for (int i = 1; i < LAT; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_meta[i] <= r_meta[i-1];
         end
      end
   end

   assign out_valid = r_vld[LAT-1];
   assign out_meta  = r_meta[LAT-1];
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_dlsc_stereobm_window_adder.sv
// Scoreboard bench for dlsc_stereobm_window_adder: one wide-output and one narrow-output
// instance share stimulus; a window-sum reference model fills per-instance expected queues.
module tb_dlsc_stereobm_window_adder;

   localparam int DATA   = 8;
   localparam int SAD    = 3;
   localparam int MULT_R = 2;
   localparam int SAD_R  = SAD + MULT_R - 1;
   localparam int META   = 4;
   localparam int SB_A   = 10;
   localparam int SB_B   = 8;
   localparam int LAT    = 4;
   localparam int WA     = META + SB_A*MULT_R;
   localparam int WB     = META + SB_B*MULT_R;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     in_valid;
   logic                     out_ready;
   logic [META-1:0]          in_meta;
   logic [DATA*SAD_R-1:0]    in_data;
   logic                     in_ready_a, in_ready_b;
   logic                     out_valid_a, out_valid_b;
   logic [META-1:0]          out_meta_a, out_meta_b;
   logic [SB_A*MULT_R-1:0]   out_data_a;
   logic [SB_B*MULT_R-1:0]   out_data_b;

   logic [WA-1:0] exp_a[$];
   logic [WB-1:0] exp_b[$];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   pops     = 0;
   int   alt_last = -1;
   logic alt_mode = 1'b0;

   always #5 clk = ~clk;

   dlsc_stereobm_window_adder #(
      .DATA(DATA), .SAD(SAD), .MULT_R(MULT_R), .SUM_BITS(SB_A), .META(META)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_meta(in_meta), .in_data(in_data), .out_valid(out_valid_a),
      .out_ready(out_ready), .out_meta(out_meta_a), .out_data(out_data_a)
   );

   dlsc_stereobm_window_adder #(
      .DATA(DATA), .SAD(SAD), .MULT_R(MULT_R), .SUM_BITS(SB_B), .META(META)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_meta(in_meta), .in_data(in_data), .out_valid(out_valid_b),
      .out_ready(out_ready), .out_meta(out_meta_b), .out_data(out_data_b)
   );

   // Reference model: window j is the plain sum of terms j..j+SAD-1, then narrowed.
   function automatic int window_sum(input logic [DATA*SAD_R-1:0] d, input int j);
      int s;
      s = 0;
      for (int k = j; k < j + SAD; k++) s += int'(d[k*DATA +: DATA]);
      return s;
   endfunction

   function automatic int narrow(input int s, input int sb);
      int mx;
      mx = (1 << sb) - 1;
`ifdef DLSC_STEREOBM_ADDER_SAT_EN
      return (s > mx) ? mx : s;
`else
      return s & mx;
`endif
   endfunction

   function automatic logic [WA-1:0] exp_a_f(input logic [META-1:0] m, input logic [DATA*SAD_R-1:0] d);
      logic [WA-1:0] e;
      e = '0;
      e[WA-1 -: META] = m;
      for (int j = 0; j < MULT_R; j++) e[j*SB_A +: SB_A] = SB_A'(narrow(window_sum(d, j), SB_A));
      return e;
   endfunction

   function automatic logic [WB-1:0] exp_b_f(input logic [META-1:0] m, input logic [DATA*SAD_R-1:0] d);
      logic [WB-1:0] e;
      e = '0;
      e[WB-1 -: META] = m;
      for (int j = 0; j < MULT_R; j++) e[j*SB_B +: SB_B] = SB_B'(narrow(window_sum(d, j), SB_B));
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && k < 50) begin
         cycle();
         k++;
      end
      check("drain_empty", 64'(exp_a.size() + exp_b.size()), 64'd0);
   endtask

   task automatic rand_beat();
      in_data = DATA*SAD_R'($urandom());
      in_meta = META'($urandom_range(0, 15));
   endtask

   // Monitor: outputs are compared against the queue head every valid cycle, popped on consume.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_a.delete();
         exp_b.delete();
      end else begin
         if (out_valid_a) begin
            if (exp_a.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL a_unexpected: out_valid=1 with no beat outstanding");
            end else begin
               check("a_beat", 64'({out_meta_a, out_data_a}), 64'(exp_a[0]));
               if (out_ready) begin
                  void'(exp_a.pop_front());
                  pops++;
                  if (alt_mode) begin
                     if (alt_last >= 0) check("alt_spacing", 64'(cyc - alt_last), 64'd2);
                     alt_last = cyc;
                  end
               end
            end
         end
         if (out_valid_b) begin
            if (exp_b.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL b_unexpected: out_valid=1 with no beat outstanding");
            end else begin
               check("b_beat", 64'({out_meta_b, out_data_b}), 64'(exp_b[0]));
               if (out_ready) void'(exp_b.pop_front());
            end
         end
         if (in_valid && in_ready_a) exp_a.push_back(exp_a_f(in_meta, in_data));
         if (in_valid && in_ready_b) exp_b.push_back(exp_b_f(in_meta, in_data));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int k;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_meta   = '0;
      in_data   = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_out_valid", 64'(out_valid_a), 64'd0);
      check("rst_out_data",  64'(out_data_a),  64'd0);
      check("rst_out_meta",  64'(out_meta_a),  64'd0);
      check("rst_in_ready",  64'(in_ready_a),  64'd1);
      check("rst_out_valid_b", 64'(out_valid_b), 64'd0);

      // Directed: terms 1,2,3,4 -> windows 6 and 9 after LAT cycles.
      in_valid = 1'b1;
      in_meta  = 4'h5;
      in_data  = {8'd4, 8'd3, 8'd2, 8'd1};
      cycle();
      in_valid = 1'b0;
      for (int t = 1; t <= LAT; t++) begin
         check("lat_valid", 64'(out_valid_a), 64'(t == LAT));
         if (t < LAT) cycle();
      end
      check("dir_w0",   64'(out_data_a[0 +: SB_A]),    64'd6);
      check("dir_w1",   64'(out_data_a[SB_A +: SB_A]), 64'd9);
      check("dir_meta", 64'(out_meta_a),               64'd5);
      check("dir_b_w0", 64'(out_data_b[0 +: SB_B]),    64'd6);
      check("dir_b_w1", 64'(out_data_b[SB_B +: SB_B]), 64'd9);
      drain();

      // All terms 255: exact 765, narrow instance wraps to 253 or clamps to 255.
      in_valid = 1'b1;
      in_meta  = 4'hA;
      in_data  = '1;
      cycle();
      in_valid = 1'b0;
      repeat (LAT - 1) cycle();
      check("max_valid", 64'(out_valid_b), 64'd1);
      check("max_a_w0", 64'(out_data_a[0 +: SB_A]),    64'd765);
      check("max_a_w1", 64'(out_data_a[SB_A +: SB_A]), 64'd765);
`ifdef DLSC_STEREOBM_ADDER_SAT_EN
      check("max_b_w0", 64'(out_data_b[0 +: SB_B]),    64'd255);
      check("max_b_w1", 64'(out_data_b[SB_B +: SB_B]), 64'd255);
`else
      check("max_b_w0", 64'(out_data_b[0 +: SB_B]),    64'd253);
      check("max_b_w1", 64'(out_data_b[SB_B +: SB_B]), 64'd253);
`endif
      drain();

      // 100 back-to-back random beats.
      p0 = pops;
      for (int i = 0; i < 100; i++) begin
         in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      in_valid = 1'b0;
      repeat (LAT) cycle();
      check("b2b_count", 64'(pops - p0), 64'd100);
      check("b2b_empty", 64'(exp_a.size()), 64'd0);

      // Fill the pipe, then hold out_ready low for 5 cycles.
      in_valid  = 1'b1;
      out_ready = 1'b1;
      k = 0;
      while (!out_valid_a && k < 20) begin
         rand_beat();
         cycle();
         k++;
      end
      check("stall_fill", 64'(out_valid_a), 64'd1);
      out_ready = 1'b0;
      repeat (5) begin
         rand_beat();
         cycle();
         check("stall_in_ready",   64'(in_ready_a),  64'd0);
         check("stall_in_ready_b", 64'(in_ready_b),  64'd0);
         check("stall_out_valid",  64'(out_valid_a), 64'd1);
      end
      drain();

      // Alternating in_valid: outputs should keep a spacing of two cycles.
      p0       = pops;
      alt_last = -1;
      alt_mode = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = (i % 2 == 0);
         rand_beat();
         cycle();
      end
      in_valid = 1'b0;
      repeat (LAT + 1) cycle();
      alt_mode = 1'b0;
      check("alt_count", 64'(pops - p0), 64'd4);
      drain();

      // Random valid and back-pressure.
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         rand_beat();
         cycle();
      end
      drain();

      // Reset with one beat at the output and three in flight.
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      in_valid = 1'b0;
      check("pre_rst_valid", 64'(out_valid_a), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid_a), 64'd0);
      check("mid_rst_data",  64'(out_data_a),  64'd0);
      check("mid_rst_meta",  64'(out_meta_a),  64'd0);
      check("mid_rst_data_b", 64'(out_data_b), 64'd0);
      repeat (2) cycle();
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", 64'(in_ready_a), 64'd1);
      repeat (10) begin
         cycle();
         check("post_rst_no_stale", 64'(out_valid_a | out_valid_b), 64'd0);
      end

      // Short random run after reset to confirm the pipe restarts cleanly.
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         rand_beat();
         cycle();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dlsc_stereobm_window_adder.md
# dlsc_stereobm_window_adder

Stall-able sliding-window SAD adder for the stereo block-matching pipeline. From `SAD+MULT_R-1` absolute-difference terms it produces `MULT_R` overlapping window sums. Window 0 is computed by a pipelined adder tree. Each following window is derived incrementally as the previous window plus the entering term minus the leaving term. Unlike the previous adder, this block has a valid/ready handshake with full back-pressure, a full-precision internal datapath, and an optional clamp on the output sums.

## Interface
- `DATA`, 16, width of each unsigned input term
- `SAD`, 15, window size in terms (>=1)
- `MULT_R`, 3, number of output windows (>=1)
- `SUM_BITS`, DATA+4, width of each output sum
- `META`, 4, width of the sideband carried alongside the data
- `SAD_R`, derived, SAD+MULT_R-1
- `INT_BITS`, derived, DATA+clog2(SAD)+1, internal sum width (cannot overflow)
- `clk`  in  1  clock, all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  block accepts the beat this cycle
- `in_meta`  in  META  sideband, carried through unchanged
- `in_data`  in  DATA*SAD_R  term k occupies bits [k*DATA +: DATA]
- `out_valid`  out  1  output beat present
- `out_ready`  in  1  consumer accepts the beat
- `out_meta`  out  META  sideband matching `out_data`
- `out_data`  out  SUM_BITS*MULT_R  window j occupies bits [j*SUM_BITS +: SUM_BITS]

## Operation
- Window j = sum of terms j .. j+SAD-1.
- Window 0 comes from a registered binary adder tree with LAT0 = clog2(SAD) levels (0 when SAD=1).
- Stage j (j=1..MULT_R-1) registers window(j-1) + term(j+SAD-1) - term(j-1).
  - The entering and leaving terms are delayed LAT0+j-1 cycles so they align with window(j-1).
- Each window is then delayed MULT_R-1-j cycles so that all windows leave on the same beat.
- A final output register applies width conversion from INT_BITS to SUM_BITS (see Configuration).
- All internal arithmetic is exact at INT_BITS. Intermediate results are never negative.
- Valid and meta travel in a shift pipeline of the same depth as the data.
- Global advance enable: `adv = !out_valid || out_ready`. Every data, valid and meta register loads only when `adv` is high.
- `in_ready = adv`, combinational from `out_valid` and `out_ready`.
- A beat is accepted when `in_valid && in_ready`.
  - If `adv` is high and `in_valid` is low, a bubble (valid=0) enters the pipe.
- Bubbles are carried through the pipe, not collapsed.

## Timing
- Latency: LAT = LAT0 + MULT_R advancing cycles from acceptance to `out_valid`.
  - Example: SAD=15, MULT_R=3 gives LAT0=4, LAT=7.
- Throughput: one beat per cycle while `out_ready` stays high.
- Stall (`out_valid && !out_ready`):
  - whole pipe freezes;
  - `out_data` and `out_meta` hold stable;
  - `in_ready` is 0 in that same cycle.
- When `out_ready` is asserted together with `out_valid`, the output is consumed and the pipe advances in that cycle.
- Reset values: `out_valid`=0, `out_meta`=0, `out_data`=0. All pipeline registers are cleared asynchronously.
- Reset mid-stream: all in-flight beats are discarded. `in_ready`=1 in the first cycle after `rst_n` rises.

## Configuration
- `DLSC_STEREOBM_ADDER_SAT_EN` defined: each output sum above 2^SUM_BITS-1 is clamped to 2^SUM_BITS-1.
- `DLSC_STEREOBM_ADDER_SAT_EN` undefined: each output is the low SUM_BITS bits of the exact sum (wraps).
- Either way the internal datapath is exact, so incremental stages are never corrupted by the clamp.
- When SUM_BITS >= INT_BITS, the output is zero-extended and the macro has no effect.

## Structure
- Package `dlsc_stereobm_adder_pkg` holds:
  - `clog2` function;
  - derivation of LAT0, LAT and INT_BITS;
  - a typedef for the internal sum width.
- Sub-module `dlsc_stereobm_window_adder_slice`:
  - one incremental stage;
  - inputs: enable, leaving-term and entering-term delay lines, prev + add - sub register;
  - instantiated MULT_R-1 times.
- The adder tree, valid/meta pipe and output clamp stay in the top module.

## Test plan
- DATA=8, SAD=3, MULT_R=2, SUM_BITS=10, terms [1,2,3,4], `out_ready`=1 -> after 4 cycles `out_valid`=1, window0=6, window1=9, meta preserved.
- Same configuration, 100 back-to-back random beats -> one output per cycle, each matching a software reference model, in order.
- SUM_BITS=8, all terms 255 (exact sum 765):
  - with the macro -> both windows 255;
  - without the macro -> both windows 253.
- `out_ready` held low for 5 cycles with the pipe full:
  - `out_data` and `out_meta` stable;
  - `in_ready`=0;
  - on release, no beat lost or duplicated.
- Alternating `in_valid` pattern 1,0,1,0 -> outputs keep the same spacing, and bubbles never assert `out_valid`.
- `rst_n` asserted with 3 beats in flight:
  - outputs go to 0 immediately;
  - no stale beat appears after release;
  - `in_ready`=1 in the first cycle after release.
